// File: rtl/fp_accum_ctrl.sv
// Sequencing controller that drives the shared fp_arith unit to reduce an operand stream
// (x0 +/- x1 +/- ...) into a single accumulated result presented on a held result port.
module fp_accum_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    LEN_W      = 16,
    parameter logic [DATA_WIDTH-1:0] ACCUM_INIT = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      vec_len,
    input  logic                  op_sel,
    output logic                  busy,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] alu_data_1,
    output logic [DATA_WIDTH-1:0] alu_data_2,
    output logic                  alu_op_sel,
    output logic                  alu_en,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    input  logic                  res_ready,
    output logic [LEN_W-1:0]      elem_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        ACCUM,
        RESULT
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [LEN_W-1:0]      r_remaining;
    logic [LEN_W-1:0]      r_elem_cnt;
    logic                  r_op;
    logic                  w_in_ready;
    logic                  w_hs;
    logic                  w_last;

    assign w_hs   = in_valid & w_in_ready;
    assign w_last = (r_remaining == LEN_W'(1));

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (vec_len == '0) ? RESULT : FIRST;
                end
            end
            FIRST, ACCUM: begin
                w_in_ready = 1'b1;
                if (w_hs) begin
                    w_next_state = w_last ? RESULT : ACCUM;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // The first operand is loaded raw rather than added to ACCUM_INIT, since
    // fp_arith has no zero-operand handling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= ACCUM_INIT;
            r_remaining <= '0;
            r_elem_cnt  <= '0;
            r_op        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op        <= op_sel;
                        r_remaining <= vec_len;
                        r_elem_cnt  <= '0;
                        if (vec_len == '0) begin
                            r_acc <= ACCUM_INIT;
                        end
                    end
                end
                FIRST: begin
                    if (w_hs) begin
                        r_acc       <= in_data;
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_elem_cnt  <= r_elem_cnt + LEN_W'(1);
                    end
                end
                ACCUM: begin
                    if (w_hs) begin
                        r_acc       <= alu_result;
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_elem_cnt  <= r_elem_cnt + LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = (r_state != IDLE);
    assign in_ready   = w_in_ready;
    assign alu_data_1 = r_acc;
    assign alu_data_2 = in_data;
    assign alu_op_sel = r_op;
    assign alu_en     = (r_state == ACCUM) & in_valid;
    assign res_valid  = (r_state == RESULT);
    assign res_data   = r_acc;
    assign elem_cnt   = r_elem_cnt;

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Self-checking bench for fp_accum_ctrl: a behavioural fp_arith stand-in plus a
// real-arithmetic reduction model checked against directed and random commands.
module tb_fp_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] vec_len;
    logic        op_sel;
    logic        busy;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] alu_data_1;
    logic [31:0] alu_data_2;
    logic        alu_op_sel;
    logic        alu_en;
    logic [31:0] alu_result;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic [15:0] elem_cnt;

    int          errorCount = 0;
    int          checkCount = 0;
    logic [31:0] stimQ[$];
    int          gapQ[$];

    fp_accum_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vec_len   (vec_len),
        .op_sel    (op_sel),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .alu_data_1(alu_data_1),
        .alu_data_2(alu_data_2),
        .alu_op_sel(alu_op_sel),
        .alu_en    (alu_en),
        .alu_result(alu_result),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .elem_cnt  (elem_cnt)
    );

    always #5 clk = ~clk;

    // Normal single-precision values only; exponent zero is treated as 0.0.
    function automatic real s2f(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) return 0.0;
        d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] f2s(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    always_comb begin
        alu_result = alu_op_sel ? f2s(s2f(alu_data_1) - s2f(alu_data_2))
                                : f2s(s2f(alu_data_1) + s2f(alu_data_2));
    end

    function automatic logic [31:0] refReduce(input int n, input logic op);
        real sum;
        if (n == 0) return 32'h0;
        sum = s2f(stimQ[0]);
        for (int k = 1; k < n; k++) begin
            sum = op ? sum - s2f(stimQ[k]) : sum + s2f(stimQ[k]);
        end
        return f2s(sum);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int len, input logic op, input int resDelay, input int overlapAt);
        logic [31:0] expected;
        int          enCount;
        enCount  = 0;
        expected = refReduce(len, op);
        @(posedge clk); #1;
        start = 1'b1; vec_len = 16'(len); op_sel = op;
        #1;
        checkOutput("idleBusy", 32'(busy), 32'd0);
        checkOutput("idleInReady", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; vec_len = 16'($urandom); op_sel = 1'($urandom);
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < gapQ[i]; g++) begin
                in_valid = 1'b0; in_data = $urandom;
                #1;
                checkOutput("gapInReady", 32'(in_ready), 32'd1);
                checkOutput("gapAluEn", 32'(alu_en), 32'd0);
                checkOutput("gapElemCnt", 32'(elem_cnt), 32'(i));
                if (i > 0) checkOutput("gapAcc", alu_data_1, refReduce(i, op));
                @(posedge clk); #1;
            end
            in_valid = 1'b1; in_data = stimQ[i];
            if (i == overlapAt) begin
                start = 1'b1; vec_len = 16'd5; op_sel = 1'b1;
            end
            #1;
            checkOutput("inReady", 32'(in_ready), 32'd1);
            checkOutput("busy", 32'(busy), 32'd1);
            checkOutput("aluOp", 32'(alu_op_sel), 32'(op));
            checkOutput("aluData2", alu_data_2, stimQ[i]);
            checkOutput("elemCnt", 32'(elem_cnt), 32'(i));
            checkOutput("aluEn", 32'(alu_en), 32'(i > 0));
            if (i > 0) checkOutput("accPartial", alu_data_1, refReduce(i, op));
            if (alu_en) enCount++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        #1;
        checkOutput("resValid", 32'(res_valid), 32'd1);
        checkOutput("resData", res_data, expected);
        checkOutput("resElemCnt", 32'(elem_cnt), 32'(len));
        checkOutput("resInReady", 32'(in_ready), 32'd0);
        checkOutput("aluEnCount", 32'(enCount), 32'((len > 0) ? len - 1 : 0));
        for (int d = 0; d < resDelay; d++) begin
            @(posedge clk); #1;
            checkOutput("holdValid", 32'(res_valid), 32'd1);
            checkOutput("holdData", res_data, expected);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        #1;
        checkOutput("backIdle", 32'(busy), 32'd0);
        checkOutput("resDropped", 32'(res_valid), 32'd0);
    endtask

    task automatic loadOperands(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input int n, input int gap);
        stimQ.delete(); gapQ.delete();
        if (n > 0) begin stimQ.push_back(a); gapQ.push_back(0); end
        if (n > 1) begin stimQ.push_back(b); gapQ.push_back(gap); end
        if (n > 2) begin stimQ.push_back(c); gapQ.push_back(gap); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; vec_len = '0; op_sel = 1'b0;
        in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstInReady", 32'(in_ready), 32'd0);
        checkOutput("rstResValid", 32'(res_valid), 32'd0);
        checkOutput("rstResData", res_data, 32'h0);
        checkOutput("rstElemCnt", 32'(elem_cnt), 32'd0);
        checkOutput("rstAluEn", 32'(alu_en), 32'd0);

        loadOperands(32'h3F800000, 32'h40000000, 32'h40400000, 3, 0);
        checkOutput("modelAdd", refReduce(3, 1'b0), 32'h40C00000);
        applyStimulus(3, 1'b0, 0, -1);

        loadOperands(32'h40C00000, 32'h40000000, 32'h3F800000, 3, 0);
        checkOutput("modelSub", refReduce(3, 1'b1), 32'h40400000);
        applyStimulus(3, 1'b1, 1, -1);

        loadOperands(32'h0, 32'h0, 32'h0, 0, 0);
        applyStimulus(0, 1'b0, 0, -1);

        loadOperands(32'h40A00000, 32'h0, 32'h0, 1, 0);
        applyStimulus(1, 1'b1, 0, -1);

        loadOperands(32'h40400000, 32'h3F800000, 32'h0, 2, 2);
        applyStimulus(2, 1'b0, 3, -1);

        stimQ.delete(); gapQ.delete();
        for (int k = 0; k < 4; k++) begin
            stimQ.push_back(f2s(real'(k + 2)));
            gapQ.push_back(0);
        end
        applyStimulus(4, 1'b0, 0, 2);

        @(posedge clk); #1;
        start = 1'b1; vec_len = 16'd4; op_sel = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h40000000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstInReady", 32'(in_ready), 32'd0);
        checkOutput("midRstResValid", 32'(res_valid), 32'd0);
        checkOutput("midRstElemCnt", 32'(elem_cnt), 32'd0);
        loadOperands(32'h3F800000, 32'h3F800000, 32'h0, 2, 0);
        applyStimulus(2, 1'b0, 0, -1);
        checkOutput("postRstSum", res_data, 32'h40000000);

        for (int t = 0; t < 25; t++) begin
            int len;
            logic op;
            len = int'($urandom_range(0, 7));
            op  = 1'($urandom);
            stimQ.delete(); gapQ.delete();
            for (int k = 0; k < len; k++) begin
                stimQ.push_back(f2s(real'($urandom_range(0, 60))));
                gapQ.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
            end
            applyStimulus(len, op, int'($urandom_range(0, 3)), (len > 2) ? int'($urandom_range(1, len - 1)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fp_accum_ctrl.md
Name: fp_accum_ctrl

Overview:
Sequencing controller for the shared single-precision fp_arith unit. It accepts a vector-reduction command (length, add/subtract) and streams operands in over a valid/ready interface. It drives the combinational FP adder/subtractor one element per cycle, holding the running result in an internal accumulator. The final value is presented on a held result interface; this block sits between the operand-fetch logic and the accumulator datapath of the accelerator.

Parameters:
DATA_WIDTH, 32, operand/result width (IEEE-754 single).
LEN_W, 16, width of vector-length field and element counter.
ACCUM_INIT, 32'h0000_0000, accumulator reset value and result for zero-length command.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  command strobe, sampled only in IDLE
vec_len  input  LEN_W  number of elements in command
op_sel  input  1  0: result = x0+x1+...+xN-1; 1: result = x0-x1-...-xN-1
busy  output  1  high whenever state != IDLE
in_valid  input  1  operand valid
in_data  input  DATA_WIDTH  operand
in_ready  output  1  controller accepts operand this cycle
alu_data_1  output  DATA_WIDTH  to fp_arith data_1 (accumulator)
alu_data_2  output  DATA_WIDTH  to fp_arith data_2 (in_data)
alu_op_sel  output  1  to fp_arith op_sel (latched op)
alu_en  output  1  to fp_arith en
alu_result  input  DATA_WIDTH  from fp_arith data_o (combinational)
res_valid  output  1  result valid, held until res_ready
res_data  output  DATA_WIDTH  final reduction value
res_ready  input  1  result consumer ready
elem_cnt  output  LEN_W  elements consumed in current command

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, acc=ACCUM_INIT, remaining=0, elem_cnt=0, op_q=0. Outputs: busy=0, in_ready=0, alu_en=0, res_valid=0, res_data=ACCUM_INIT.
- alu_data_1=acc, alu_data_2=in_data, alu_op_sel=op_q: combinational at all times. alu_en=(state==ACCUM)&in_valid. res_data=acc.
- FSM states IDLE, FIRST, ACCUM, RESULT. A handshake (hs) is in_valid&in_ready.
- IDLE: in_ready=0. On start: latch op_q=op_sel and remaining=vec_len, clear elem_cnt. If vec_len==0, set acc=ACCUM_INIT and go to RESULT; otherwise go to FIRST.
- FIRST: in_ready=1. On hs: acc=in_data (loaded raw, never added to ACCUM_INIT, because fp_arith has no zero handling), remaining-1, elem_cnt+1. Go to RESULT if remaining==1, else to ACCUM.
- ACCUM: in_ready=1. On hs: acc=alu_result, remaining-1, elem_cnt+1. Go to RESULT if remaining==1. Without hs, all state holds.
- RESULT: res_valid=1, in_ready=0. On res_ready, go to IDLE; acc keeps its value until the next command.
- Throughput: 1 element/cycle with in_valid held. Latency: res_valid asserts the cycle after the last hs.
- start while busy: ignored, no effect on latched len/op.
- start and in_valid in the same IDLE cycle: no operand is consumed (in_ready=0); the first operand is taken in FIRST at the earliest on the next cycle.
- Gaps in in_valid: acc, remaining, elem_cnt hold; alu_en low.
- res_ready low: res_valid and res_data stay stable indefinitely.
- Reset mid-command: the partial result is discarded, and the reset values above apply on the cycle after the reset edge.
- The counter never wraps. The maximum vec_len is 2^LEN_W-1, and elem_cnt reaches vec_len exactly.

Test Plan:
- Add: start, len=3, op=0, stream 3F800000, 40000000, 40400000 back-to-back. Required: res_valid 1 cycle after 3rd hs; res_data=40C00000 (6.0); elem_cnt=3; alu_en high exactly 2 cycles.
- Subtract: len=3, op=1, stream 40C00000, 40000000, 3F800000. Required: res_data=40400000 (3.0).
- Zero/one length: len=0 gives res_valid the cycle after start, res_data=00000000, in_ready never high. len=1 with 40A00000 gives res_data=40A00000, alu_en never high.
- Backpressure: len=2 add, in_valid low 2 cycles between operands, res_ready held low 3 cycles. Required: in_ready/acc/elem_cnt hold during gaps; res_data stable for all 3 cycles; IDLE after res_ready.
- Busy/overlap: start pulsed with len=5, op=1 during ACCUM of a len=4 add command. Required: the original command completes as add with 4 elements; the second start is ignored.
- Reset mid-stream: rst_n low after 2 of 4 operands. Required: next cycle busy=0, in_ready=0, res_valid=0, elem_cnt=0; a fresh len=2 add of 3F800000+3F800000 then gives 40000000.
